// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle FSM sequencing a shared ALU and RAM port.
// Drives all datapath strobes; MOV/MOC RAM handshake with a timeout watchdog.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        moc,
  output logic        mov,
  output logic        mem_rw,
  output logic        addr_sel,
  output logic        ir_load,
  output logic        pc_load,
  output logic [1:0]  pc_src,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        fault
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  state_t           stateQ;
  state_t           stateNext;
  logic [5:0]       opQ;
  logic [CNT_W-1:0] cntQ;
  logic             timeout;
  logic             unusedInstr;

  assign unusedInstr = ^instr[25:0];
  assign timeout     = (cntQ == CNT_W'(MEM_TIMEOUT)) && !moc;
  assign state       = stateQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= FETCH;
      opQ    <= '0;
      cntQ   <= '0;
      fault  <= 1'b0;
    end else begin
      stateQ <= stateNext;
      if (stateQ == DECODE)
        opQ <= instr[31:26];
      if (stateNext != stateQ &&
          (stateNext == FETCH || stateNext == MEM))
        cntQ <= '0;
      else if (mov && !moc)
        cntQ <= cntQ + CNT_W'(1);
      if (stateNext == HALT)
        fault <= 1'b1;
    end
  end

  always_comb begin
    stateNext  = stateQ;
    mov        = 1'b0;
    mem_rw     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    pc_src     = 2'b00;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;
    unique case (stateQ)
      FETCH: begin
        mov    = 1'b1;
        mem_rw = 1'b1;
        if (moc) begin
          ir_load   = 1'b1;
          pc_load   = 1'b1;
          stateNext = DECODE;
        end else if (timeout) begin
          stateNext = HALT;
        end
      end
      DECODE: begin
        case (instr[31:26])
          OP_J: begin
            pc_load   = 1'b1;
            pc_src    = 2'b10;
            stateNext = FETCH;
          end
          OP_R, OP_LW, OP_SW,
          OP_BEQ, OP_BNE, OP_ADDI:
            stateNext = EXEC;
          default:
            stateNext = FETCH;
        endcase
      end
      EXEC: begin
        case (opQ)
          OP_R: begin
            alu_op    = 2'b10;
            stateNext = WB;
          end
          OP_BEQ, OP_BNE: begin
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            pc_load   = (opQ == OP_BEQ) ? zero : !zero;
            stateNext = FETCH;
          end
          OP_ADDI: begin
            alu_src   = 1'b1;
            stateNext = WB;
          end
          default: begin
            alu_src   = 1'b1;
            stateNext = MEM;
          end
        endcase
      end
      MEM: begin
        mov      = 1'b1;
        addr_sel = 1'b1;
        mem_rw   = (opQ == OP_LW);
        if (moc)
          stateNext = (opQ == OP_LW) ? WB : FETCH;
        else if (timeout)
          stateNext = HALT;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opQ == OP_R);
        mem_to_reg = (opQ == OP_LW);
        stateNext  = FETCH;
      end
      HALT:
        stateNext = HALT;
      default:
        stateNext = FETCH;
    endcase
    // Strobes must be dead while reset is held, even though FETCH is the reset state
    if (reset) begin
      mov        = 1'b0;
      mem_rw     = 1'b0;
      addr_sel   = 1'b0;
      ir_load    = 1'b0;
      pc_load    = 1'b0;
      pc_src     = 2'b00;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      alu_op     = 2'b00;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: per-instruction model of the multicycle control
// sequence, compared against the DUT on every cycle.
module tb_mips_multicycle_ctrl;

  localparam int TO = 15;

  typedef struct packed {
    logic       mov;
    logic       memRw;
    logic       addrSel;
    logic       irLoad;
    logic       pcLoad;
    logic [1:0] pcSrc;
    logic       regDst;
    logic       regWrite;
    logic       aluSrc;
    logic       memToReg;
    logic [1:0] aluOp;
    logic [2:0] st;
    logic       flt;
  } outs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        moc;
  logic        mov, mem_rw, addr_sel, ir_load, pc_load;
  logic [1:0]  pc_src;
  logic        reg_dst, reg_write, alu_src, mem_to_reg;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic        fault;

  outs_t dut;
  outs_t outTrace[$];
  int    applied = 0;
  int    miscompares = 0;

  assign dut = {mov, mem_rw, addr_sel, ir_load, pc_load, pc_src,
                reg_dst, reg_write, alu_src, mem_to_reg, alu_op,
                state, fault};

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .moc(moc),
    .mov(mov), .mem_rw(mem_rw), .addr_sel(addr_sel),
    .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .alu_op(alu_op), .state(state),
    .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "stuck");
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Single compare point: every model cycle checks the full output vector.
  task automatic step(input string nm, input outs_t e);
    @(negedge clk);
    outTrace.push_back(dut);
    check(nm, {15'd0, dut}, {15'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset(input string nm);
    outs_t z;
    z = '0;
    reset = 1'b1;
    #1;
    check({nm, "_rstNow"}, {15'd0, dut}, {15'd0, z});
    @(posedge clk);
    #1;
    check({nm, "_rstHeld"}, {15'd0, dut}, {15'd0, z});
    reset = 1'b0;
    moc = 1'b0;
  endtask

  function automatic bit isKnown(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B ||
           op == 6'h04 || op == 6'h05 || op == 6'h08;
  endfunction

  // fw/mw: wait cycles before moc in FETCH/MEM; hold keeps moc high
  // throughout; rstAt resets at that MEM wait cycle (-1 = never).
  task automatic doInstr(input string nm, input logic [5:0] op,
                         input logic z, input int fw, input int mw,
                         input bit hold, input int rstAt);
    outs_t e;
    bit    isLw, isSw, isBr;
    isLw = (op == 6'h23);
    isSw = (op == 6'h2B);
    isBr = (op == 6'h04 || op == 6'h05);
    outTrace.delete();
    zero = z;
    for (int i = 0; i <= fw; i++) begin
      moc = hold || (i == fw);
      e = '0;
      e.mov = 1'b1;
      e.memRw = 1'b1;
      if (i == fw) begin
        e.irLoad = 1'b1;
        e.pcLoad = 1'b1;
      end
      step({nm, "_fetch"}, e);
    end
    instr = {op, 26'($urandom)};
    moc = hold;
    e = '0;
    e.st = 3'd1;
    if (op == 6'h02) begin
      e.pcLoad = 1'b1;
      e.pcSrc = 2'b10;
    end
    step({nm, "_decode"}, e);
    if (!isKnown(op)) begin
      moc = 1'b0;
      return;
    end
    e = '0;
    e.st = 3'd2;
    if (op == 6'h00) begin
      e.aluOp = 2'b10;
    end else if (isBr) begin
      e.aluOp = 2'b01;
      e.pcSrc = 2'b01;
      e.pcLoad = (op == 6'h04) ? z : !z;
    end else begin
      e.aluSrc = 1'b1;
    end
    step({nm, "_exec"}, e);
    if (isBr) begin
      moc = 1'b0;
      return;
    end
    if (isLw || isSw) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == rstAt) begin
          moc = 1'b0;
          #1;
          check({nm, "_preRstMov"}, 32'(mov), 32'd1);
          pulseReset(nm);
          return;
        end
        if (i == TO + 1) begin
          e = '0;
          e.st = 3'd7;
          e.flt = 1'b1;
          for (int k = 0; k < 3; k++) begin
            moc = k[0];
            step({nm, "_halt"}, e);
          end
          pulseReset(nm);
          return;
        end
        moc = hold || (i == mw);
        e = '0;
        e.st = 3'd3;
        e.mov = 1'b1;
        e.addrSel = 1'b1;
        e.memRw = isLw;
        step({nm, "_mem"}, e);
      end
      moc = hold;
      if (isSw) begin
        moc = 1'b0;
        return;
      end
    end
    e = '0;
    e.st = 3'd4;
    e.regWrite = 1'b1;
    e.regDst = (op == 6'h00);
    e.memToReg = isLw;
    step({nm, "_wb"}, e);
    moc = 1'b0;
  endtask

  initial begin
    outs_t e;
    int    n;
    int    lwSeq[5];
    lwSeq = '{0, 1, 2, 3, 4};
    reset = 1'b1;
    instr = '0;
    zero  = 1'b0;
    moc   = 1'b0;
    #3;
    check("resetOutputs", {15'd0, dut}, 32'd0);
    @(posedge clk);
    #1;
    check("resetHeld", {15'd0, dut}, 32'd0);
    reset = 1'b0;

    doInstr("lw", 6'h23, 1'b0, 0, 0, 1'b0, -1);
    check("lwLen", outTrace.size(), 5);
    for (int k = 0; k < 5; k++)
      check("lwSeq", 32'(outTrace[k].st), 32'(lwSeq[k]));
    check("lwWbStrobes", {outTrace[4].regWrite, outTrace[4].memToReg,
                          outTrace[4].regDst}, 32'b110);

    doInstr("beqT", 6'h04, 1'b1, 0, 0, 1'b0, -1);
    check("beqLen", outTrace.size(), 3);
    check("beqPc", {outTrace[2].pcLoad, outTrace[2].pcSrc}, 32'b101);
    doInstr("bneT", 6'h05, 1'b1, 0, 0, 1'b0, -1);
    check("bneNoLoad", 32'(outTrace[2].pcLoad), 32'd0);
    doInstr("beqF", 6'h04, 1'b0, 1, 0, 1'b0, -1);
    doInstr("bneF", 6'h05, 1'b0, 0, 0, 1'b0, -1);

    doInstr("j", 6'h02, 1'b0, 0, 0, 1'b0, -1);
    check("jLen", outTrace.size(), 2);
    check("jPc", {outTrace[1].pcLoad, outTrace[1].pcSrc}, 32'b110);

    doInstr("rtype", 6'h00, 1'b0, 2, 0, 1'b0, -1);
    check("rLen", outTrace.size(), 6);
    doInstr("addi", 6'h08, 1'b1, 0, 0, 1'b0, -1);
    check("addiLen", outTrace.size(), 4);
    doInstr("sw", 6'h2B, 1'b0, 0, 3, 1'b0, -1);
    check("swLen", outTrace.size(), 7);
    doInstr("lwHold", 6'h23, 1'b0, 0, 0, 1'b1, -1);
    check("lwHoldLen", outTrace.size(), 5);

    doInstr("bad3F", 6'h3F, 1'b0, 0, 0, 1'b0, -1);
    check("badLen", outTrace.size(), 2);
    check("badQuiet", {outTrace[1].regWrite, outTrace[1].pcLoad}, 32'd0);

    doInstr("lwMemEdge", 6'h23, 1'b0, 0, TO, 1'b0, -1);
    doInstr("lwMemTo", 6'h23, 1'b0, 0, 99, 1'b0, -1);

    outTrace.delete();
    moc = 1'b0;
    e = '0;
    e.mov = 1'b1;
    e.memRw = 1'b1;
    for (int i = 0; i <= TO; i++)
      step("fetchTo_fetch", e);
    e = '0;
    e.st = 3'd7;
    e.flt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      moc = k[0];
      step("fetchTo_halt", e);
    end
    n = 0;
    foreach (outTrace[k])
      if (outTrace[k].st == 3'd0) n++;
    check("fetchToLen", n, 16);
    pulseReset("fetchTo");

    doInstr("fetch16", 6'h00, 1'b0, TO, 0, 1'b0, -1);
    check("fetch16Len", outTrace.size(), 19);

    doInstr("swRst", 6'h2B, 1'b0, 0, 5, 1'b0, 1);
    doInstr("afterRst", 6'h00, 1'b0, 0, 0, 1'b0, -1);
    doInstr("afterRstLw", 6'h23, 1'b0, 1, 2, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
